alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 167 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter (with helper module execute)
// Purpose  : Shares one execute ALU between two requesters. A granted
//            operation is latched in IDLE, evaluated in EXEC and presented
//            in RESP until the consumer takes it.
// Ports    : clk, reset              - clock, synchronous active-high reset
//            req{0,1}_valid/ready    - request handshakes
//            req{0,1}_src1/src2/ctrl - operands and alu_control code
//            resp_valid/ready        - response handshake
//            resp_id/data/zero       - owning requester, ALU result, zero flag
//            busy                    - high in any state other than IDLE
// Config   : ALU_ARBITER_ROUND_ROBIN_EN - alternate the grant when both
//            requesters are valid; undefined gives fixed priority to req0.
// Revision : 1.0 - initial release
// ============================================================================

module execute #(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        alu_control,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic [DATA_W-1:0] alu_out,
  output logic              zero
);
  always_comb begin
    alu_out = '0;
    case (alu_control)
      4'b0000: alu_out = src1 + src2;
      4'b0001: alu_out = src1 - src2;
      4'b0010: alu_out = src1 & src2;
      4'b0011: alu_out = src1 | src2;
      4'b0100: alu_out = src1 ^ src2;
      4'b0101: alu_out = src1 << src2[4:0];
      4'b0110: alu_out = src1 >> src2[4:0];
      4'b0111: alu_out = $signed(src1) >>> src2[4:0];
      4'b1000: alu_out = {{(DATA_W-1){1'b0}}, $signed(src1) < $signed(src2)};
      4'b1001: alu_out = {{(DATA_W-1){1'b0}}, src1 < src2};
      default: alu_out = '0;
    endcase
  end

  assign zero = (alu_out == '0);
endmodule

module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req0_src1,
  input  logic [DATA_W-1:0] req0_src2,
  input  logic [DATA_W-1:0] req1_src1,
  input  logic [DATA_W-1:0] req1_src2,
  input  logic [3:0]        req0_ctrl,
  input  logic [3:0]        req1_ctrl,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_zero,
  output logic              busy
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state, next_state;
  logic [DATA_W-1:0] op_src1, op_src2;
  logic [3:0]        op_ctrl;
  logic              op_id;
  logic [DATA_W-1:0] resp_data_q;
  logic              resp_zero_q;
  logic [DATA_W-1:0] alu_out;
  logic              alu_zero;
  logic              grant_id;
  logic              handshake;

  // The ALU only ever sees the latched operands, so its inputs are stable
  // for the whole EXEC cycle regardless of what the requesters do.
  execute #(.DATA_W(DATA_W)) u_execute (
    .alu_control(op_ctrl),
    .src1       (op_src1),
    .src2       (op_src2),
    .alu_out    (alu_out),
    .zero       (alu_zero)
  );

`ifdef ALU_ARBITER_ROUND_ROBIN_EN
  logic last_grant;

  // A lone valid requester always wins; only contention consults history.
  always_comb begin
    grant_id = req1_valid;
    if (req0_valid && req1_valid) grant_id = ~last_grant;
  end
`else
  always_comb begin
    grant_id = ~req0_valid;
  end
`endif

  always_comb begin
    next_state = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    resp_valid = 1'b0;
    handshake  = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = req0_valid & ~grant_id;
        req1_ready = req1_valid &  grant_id;
        handshake  = req0_ready | req1_ready;
        if (handshake) next_state = EXEC;
      end
      EXEC: next_state = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      op_src1     <= '0;
      op_src2     <= '0;
      op_ctrl     <= '0;
      op_id       <= 1'b0;
      resp_data_q <= '0;
      resp_zero_q <= 1'b0;
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
      last_grant  <= 1'b1;
`endif
    end else begin
      state <= next_state;
      if (handshake) begin
        op_src1 <= grant_id ? req1_src1 : req0_src1;
        op_src2 <= grant_id ? req1_src2 : req0_src2;
        op_ctrl <= grant_id ? req1_ctrl : req0_ctrl;
        op_id   <= grant_id;
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
        last_grant <= grant_id;
`endif
      end
      if (state == EXEC) begin
        resp_data_q <= alu_out;
        resp_zero_q <= alu_zero;
      end
    end
  end

  assign resp_id   = op_id;
  assign resp_data = resp_data_q;
  assign resp_zero = resp_zero_q;
  assign busy      = (state != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Directed self-checking bench for alu_arbiter: reset state,
//            add/sub results, zero flag, contention order, backpressure and
//            reset in the middle of an operation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic        resp_valid, resp_ready;
  logic        resp_id;
  logic [31:0] resp_data;
  logic        resp_zero;
  logic        busy;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0_valid(req0_valid),
    .req1_valid(req1_valid),
    .req0_ready(req0_ready),
    .req1_ready(req1_ready),
    .req0_src1 (req0_src1),
    .req0_src2 (req0_src2),
    .req1_src1 (req1_src1),
    .req1_src2 (req1_src2),
    .req0_ctrl (req0_ctrl),
    .req1_ctrl (req1_ctrl),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_id   (resp_id),
    .resp_data (resp_data),
    .resp_zero (resp_zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rv"},   {31'd0, resp_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy},       32'd0);
  endtask

  logic exp_id [4];
  logic [31:0] exp_d;

  initial begin
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
    exp_id[0] = 1'b0; exp_id[1] = 1'b1; exp_id[2] = 1'b0; exp_id[3] = 1'b1;
`else
    exp_id[0] = 1'b0; exp_id[1] = 1'b0; exp_id[2] = 1'b0; exp_id[3] = 1'b0;
`endif
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
    req0_src1 = '0; req0_src2 = '0; req1_src1 = '0; req1_src2 = '0;
    req0_ctrl = '0; req1_ctrl = '0;
    step(); step();

    // Reset state
    chk("rst_r0",   {31'd0, req0_ready}, 32'd0);
    chk("rst_r1",   {31'd0, req1_ready}, 32'd0);
    chk("rst_rv",   {31'd0, resp_valid}, 32'd0);
    chk("rst_id",   {31'd0, resp_id},    32'd0);
    chk("rst_data", resp_data,           32'd0);
    chk("rst_zero", {31'd0, resp_zero},  32'd0);
    chk("rst_busy", {31'd0, busy},       32'd0);

    // Reset takes priority over a handshake presented during reset
    req0_valid = 1'b1; req0_src1 = 32'd1; req0_src2 = 32'd1;
    step();
    chk("rstprio_busy", {31'd0, busy}, 32'd0);
    req0_valid = 1'b0;
    reset = 1'b0;
    step();

    // Single request: 5 + 4 = 9 from req0
    req0_valid = 1'b1; req0_src1 = 32'd5; req0_src2 = 32'd4; req0_ctrl = 4'b0000;
    #1;
    chk("t1_r0", {31'd0, req0_ready}, 32'd1);
    chk("t1_r1", {31'd0, req1_ready}, 32'd0);
    step();                                   // handshake cycle N
    req0_valid = 1'b0;
    chk("t1_exec_busy", {31'd0, busy},       32'd1);
    chk("t1_exec_rv",   {31'd0, resp_valid}, 32'd0);
    chk("t1_exec_r0",   {31'd0, req0_ready}, 32'd0);
    step();                                   // cycle N+2
    chk("t1_rv",   {31'd0, resp_valid}, 32'd1);
    chk("t1_data", resp_data,           32'd9);
    chk("t1_zero", {31'd0, resp_zero},  32'd0);
    chk("t1_id",   {31'd0, resp_id},    32'd0);
    step();
    chk_idle_outputs("t1_done");

    // Zero flag: 3 - 3 from req1
    req1_valid = 1'b1; req1_src1 = 32'd3; req1_src2 = 32'd3; req1_ctrl = 4'b0001;
    #1;
    chk("t2_r1", {31'd0, req1_ready}, 32'd1);
    chk("t2_r0", {31'd0, req0_ready}, 32'd0);
    step();
    req1_valid = 1'b0;
    step();
    chk("t2_rv",   {31'd0, resp_valid}, 32'd1);
    chk("t2_data", resp_data,           32'd0);
    chk("t2_zero", {31'd0, resp_zero},  32'd1);
    chk("t2_id",   {31'd0, resp_id},    32'd1);
    step();

    // Contention: both valid for four operations
    req0_valid = 1'b1; req0_src1 = 32'd20;  req0_src2 = 32'd5; req0_ctrl = 4'b0001; // 15
    req1_valid = 1'b1; req1_src1 = 32'd100; req1_src2 = 32'd1; req1_ctrl = 4'b0000; // 101
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("c%0d_r0", k), {31'd0, req0_ready}, {31'd0, ~exp_id[k]});
      chk($sformatf("c%0d_r1", k), {31'd0, req1_ready}, {31'd0,  exp_id[k]});
      step();
      step();
      exp_d = exp_id[k] ? 32'd101 : 32'd15;
      chk($sformatf("c%0d_rv", k),   {31'd0, resp_valid}, 32'd1);
      chk($sformatf("c%0d_id", k),   {31'd0, resp_id},    {31'd0, exp_id[k]});
      chk($sformatf("c%0d_data", k), resp_data,           exp_d);
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();

    // Backpressure: 2 + 2 = 4 from req0, held five cycles, req1 waiting
    resp_ready = 1'b0;
    req0_valid = 1'b1; req0_src1 = 32'd2; req0_src2 = 32'd2; req0_ctrl = 4'b0000;
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_src1 = 32'd7; req1_src2 = 32'd7; req1_ctrl = 4'b0001;
    step();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d_rv", k),   {31'd0, resp_valid}, 32'd1);
      chk($sformatf("bp%0d_data", k), resp_data,           32'd4);
      chk($sformatf("bp%0d_id", k),   {31'd0, resp_id},    32'd0);
      chk($sformatf("bp%0d_rdy", k),  {30'd0, req0_ready, req1_ready}, 32'd0);
      step();
    end
    resp_ready = 1'b1;
    step();
    chk("bp_rel_rv",   {31'd0, resp_valid}, 32'd0);
    chk("bp_rel_busy", {31'd0, busy},       32'd0);
    chk("bp_rel_r1",   {31'd0, req1_ready}, 32'd1);
    req1_valid = 1'b0;
    step();

    // Reset in EXEC drops the operation; req0 then wins under contention
    req0_valid = 1'b1; req0_src1 = 32'd9; req0_src2 = 32'd9; req0_ctrl = 4'b0000;
    step();
    req0_valid = 1'b0;
    chk("rm_exec_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rm_busy", {31'd0, busy},       32'd0);
    chk("rm_rv",   {31'd0, resp_valid}, 32'd0);
    chk("rm_data", resp_data,           32'd0);
    chk("rm_id",   {31'd0, resp_id},    32'd0);
    chk("rm_zero", {31'd0, resp_zero},  32'd0);
    step();
    chk("rm_norv", {31'd0, resp_valid}, 32'd0);
    req0_valid = 1'b1; req0_src1 = 32'd6; req0_src2 = 32'd1; req0_ctrl = 4'b0000;
    req1_valid = 1'b1; req1_src1 = 32'd1; req1_src2 = 32'd1; req1_ctrl = 4'b0000;
    #1;
    chk("rm_r0", {31'd0, req0_ready}, 32'd1);
    chk("rm_r1", {31'd0, req1_ready}, 32'd0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    chk("rm_resp_id",   {31'd0, resp_id}, 32'd0);
    chk("rm_resp_data", resp_data,        32'd7);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
